// File: rtl/tx_pend_sched.sv
// Per-flow pending-work tracker (ack/data/rt bits) with a round-robin scanner
// that hands one flow at a time, with the kinds it had pending, to the TX engine.
module tx_pend_sched #(
  parameter int MAX_FLOW_CNT = 16,
  parameter int NUM_FLOWS    = MAX_FLOW_CNT,
  parameter int FLOWID_W     = $clog2(NUM_FLOWS)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                s0_cmd_val,
  input  logic [FLOWID_W-1:0] s0_cmd_flowid,
  input  logic [1:0]          s0_cmd_ack,
  input  logic [1:0]          s0_cmd_data,
  input  logic [1:0]          s0_cmd_rt,
  output logic                s0_cmd_rdy,

  input  logic                s1_cmd_val,
  input  logic [FLOWID_W-1:0] s1_cmd_flowid,
  input  logic [1:0]          s1_cmd_ack,
  input  logic [1:0]          s1_cmd_data,
  input  logic [1:0]          s1_cmd_rt,
  output logic                s1_cmd_rdy,

  output logic                tx_req_val,
  output logic [FLOWID_W-1:0] tx_req_flowid,
  output logic [2:0]          tx_req_kinds,
  input  logic                tx_req_rdy
);

  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;

  typedef enum logic {SCAN, ISSUE} state_t;

  state_t                         state_q, state_d;
  logic [FLOWID_W-1:0]            ptr_q, ptr_d;
  logic [FLOWID_W-1:0]            flowid_q, flowid_d;
  logic [2:0]                     kinds_q, kinds_d;
  logic [NUM_FLOWS-1:0][2:0]      pend_q, pend_d;

  logic                           cmd_val;
  logic [FLOWID_W-1:0]            cmd_flowid;
  logic [2:0][1:0]                cmd_op;

  assign s0_cmd_rdy    = 1'b1;
  assign s1_cmd_rdy    = ~s0_cmd_val;
  assign tx_req_val    = (state_q == ISSUE);
  assign tx_req_flowid = flowid_q;
  assign tx_req_kinds  = kinds_q;

  // s0 always wins; s1 only lands in cycles where s0 is idle.
  always_comb begin
    cmd_val    = s0_cmd_val | s1_cmd_val;
    cmd_flowid = s1_cmd_flowid;
    cmd_op     = {s1_cmd_rt, s1_cmd_data, s1_cmd_ack};
    if (s0_cmd_val) begin
      cmd_flowid = s0_cmd_flowid;
      cmd_op     = {s0_cmd_rt, s0_cmd_data, s0_cmd_ack};
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    flowid_d = flowid_q;
    kinds_d  = kinds_q;
    pend_d   = pend_q;

    case (state_q)
      SCAN: begin
        if (|pend_q[ptr_q]) begin
          flowid_d       = ptr_q;
          kinds_d        = pend_q[ptr_q];
          pend_d[ptr_q]  = 3'b000;
          state_d        = ISSUE;
        end else begin
          ptr_d = ptr_q + FLOWID_W'(1);
        end
      end
      ISSUE: begin
        if (tx_req_rdy) begin
          ptr_d   = ptr_q + FLOWID_W'(1);
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase

    // Applied after the grab clear so the command wins a same-cycle collision;
    // a NOP then leaves the just-cleared 0 in place.
    if (cmd_val) begin
      for (int k = 0; k < 3; k++) begin
        if (cmd_op[k] == OP_SET)      pend_d[cmd_flowid][k] = 1'b1;
        else if (cmd_op[k] == OP_CLR) pend_d[cmd_flowid][k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      ptr_q    <= '0;
      flowid_q <= '0;
      kinds_q  <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      flowid_q <= flowid_d;
      kinds_q  <= kinds_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_tx_pend_sched.sv
// Randomized + directed bench for tx_pend_sched against a flow-table model.
module tb_tx_pend_sched;
  localparam int NF = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_cmd_val = 1'b0, s1_cmd_val = 1'b0;
  logic [FW-1:0] s0_cmd_flowid = '0, s1_cmd_flowid = '0;
  logic [1:0]    s0_cmd_ack = '0, s0_cmd_data = '0, s0_cmd_rt = '0;
  logic [1:0]    s1_cmd_ack = '0, s1_cmd_data = '0, s1_cmd_rt = '0;
  logic          s0_cmd_rdy, s1_cmd_rdy;
  logic          tx_req_val;
  logic [FW-1:0] tx_req_flowid;
  logic [2:0]    tx_req_kinds;
  logic          tx_req_rdy = 1'b0;

  tx_pend_sched #(.NUM_FLOWS(NF)) dut (
    .clk(clk), .rst(rst),
    .s0_cmd_val(s0_cmd_val), .s0_cmd_flowid(s0_cmd_flowid),
    .s0_cmd_ack(s0_cmd_ack), .s0_cmd_data(s0_cmd_data), .s0_cmd_rt(s0_cmd_rt),
    .s0_cmd_rdy(s0_cmd_rdy),
    .s1_cmd_val(s1_cmd_val), .s1_cmd_flowid(s1_cmd_flowid),
    .s1_cmd_ack(s1_cmd_ack), .s1_cmd_data(s1_cmd_data), .s1_cmd_rt(s1_cmd_rt),
    .s1_cmd_rdy(s1_cmd_rdy),
    .tx_req_val(tx_req_val), .tx_req_flowid(tx_req_flowid),
    .tx_req_kinds(tx_req_kinds), .tx_req_rdy(tx_req_rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;
  int glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Model: a table of pending bits per flow, a scan position, and the
  // current grant (if any). Each clock applies the scheduler rule, then
  // the winning command overwrites the touched bits.
  logic [2:0] m_pend [NF];
  int         m_ptr = 0;
  bit         m_issue = 1'b0;
  int         m_fid = 0;
  logic [2:0] m_kinds = '0;

  always @(posedge clk) begin : mdl
    logic [2:0] np [NF];
    logic [1:0] op [3];
    int nptr, nfid, cf;
    bit niss;
    logic [2:0] nk;
    if (rst) begin
      for (int i = 0; i < NF; i++) m_pend[i] <= 3'b0;
      m_ptr <= 0; m_issue <= 1'b0; m_fid <= 0; m_kinds <= 3'b0;
    end else begin
      np = m_pend; nptr = m_ptr; niss = m_issue; nfid = m_fid; nk = m_kinds;
      if (!m_issue) begin
        if (m_pend[m_ptr] != 3'b0) begin
          niss = 1'b1; nfid = m_ptr; nk = m_pend[m_ptr]; np[m_ptr] = 3'b0;
        end else nptr = (m_ptr + 1) % NF;
      end else if (tx_req_rdy) begin
        niss = 1'b0; nptr = (m_ptr + 1) % NF;
      end
      if (s0_cmd_val) begin
        cf = int'(s0_cmd_flowid); op[0] = s0_cmd_ack; op[1] = s0_cmd_data; op[2] = s0_cmd_rt;
      end else begin
        cf = int'(s1_cmd_flowid); op[0] = s1_cmd_ack; op[1] = s1_cmd_data; op[2] = s1_cmd_rt;
      end
      if (s0_cmd_val || s1_cmd_val)
        for (int k = 0; k < 3; k++) begin
          if (op[k] == 2'd1) np[cf][k] = 1'b1;
          else if (op[k] == 2'd2) np[cf][k] = 1'b0;
        end
      m_pend <= np; m_ptr <= nptr; m_issue <= niss; m_fid <= nfid; m_kinds <= nk;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("s0_rdy", 32'(s0_cmd_rdy), 32'd1);
      chk("s1_rdy", 32'(s1_cmd_rdy), 32'(!s0_cmd_val));
      chk("req_val", 32'(tx_req_val), 32'(m_issue));
      if (m_issue) begin
        chk("req_flowid", 32'(tx_req_flowid), 32'(m_fid));
        chk("req_kinds", 32'(tx_req_kinds), 32'(m_kinds));
        chk("kinds_nonzero", 32'(tx_req_kinds != 3'b0), 32'd1);
      end
      if (tx_req_val && tx_req_rdy && !rst)
        glog.push_back(int'(tx_req_flowid) * 8 + int'(tx_req_kinds));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    s0_cmd_val = 1'b0; s1_cmd_val = 1'b0;
    s0_cmd_ack = '0; s0_cmd_data = '0; s0_cmd_rt = '0;
    s1_cmd_ack = '0; s1_cmd_data = '0; s1_cmd_rt = '0;
  endtask

  task automatic cmd0(input int f, input logic [1:0] a, input logic [1:0] d, input logic [1:0] r);
    s0_cmd_val = 1'b1; s0_cmd_flowid = FW'(f);
    s0_cmd_ack = a; s0_cmd_data = d; s0_cmd_rt = r;
  endtask

  task automatic cmd1(input int f, input logic [1:0] a, input logic [1:0] d, input logic [1:0] r);
    s1_cmd_val = 1'b1; s1_cmd_flowid = FW'(f);
    s1_cmd_ack = a; s1_cmd_data = d; s1_cmd_rt = r;
  endtask

  // Leaves the bench just after a reset edge; the next edge is cycle 0 with ptr=0.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    glog.delete();
  endtask

  task automatic wait_val(input int budget);
    int n = 0;
    while (!tx_req_val && n < budget) begin cyc(1); n++; end
    chk("wait_val_timeout", 32'(tx_req_val), 32'd1);
  endtask

  task automatic chk_log(input string nm, input int exp[$]);
    chk({nm, "_count"}, 32'(glog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk({nm, "_entry"}, 32'(glog[i]), 32'(exp[i]));
  endtask

  initial begin
    int q[$];
    int n;
    logic [FW-1:0] f0;
    logic [2:0]    k0;
    do_reset();
    armed = 1'b1;
    chk("reset_val", 32'(tx_req_val), 32'd0);
    chk("reset_flowid", 32'(tx_req_flowid), 32'd0);
    chk("reset_kinds", 32'(tx_req_kinds), 32'd0);

    // single rt on flow 5 -> exactly one grant (5, rt)
    tx_req_rdy = 1'b1;
    cmd1(5, 2'd0, 2'd0, 2'd1); cyc(1); idle(); cyc(40);
    q = '{5*8+4}; chk_log("rt_flow5", q);

    // s0 and s1 collide on flow 3; s1 dropped after one cycle
    do_reset(); tx_req_rdy = 1'b1;
    cmd0(3, 2'd1, 2'd0, 2'd0); cmd1(3, 2'd0, 2'd1, 2'd0); #1;
    chk("s1_blocked", 32'(s1_cmd_rdy), 32'd0);
    cyc(1); idle(); cyc(40);
    q = '{3*8+1}; chk_log("s0_prio_drop", q);

    // same collision, s1 held one more cycle
    do_reset(); tx_req_rdy = 1'b1;
    cmd0(3, 2'd1, 2'd0, 2'd0); cmd1(3, 2'd0, 2'd1, 2'd0); cyc(1);
    s0_cmd_val = 1'b0; #1;
    chk("s1_released", 32'(s1_cmd_rdy), 32'd1);
    cyc(1); idle(); cyc(40);
    q = '{3*8+3}; chk_log("s0_prio_hold", q);

    // round robin 2,7,15 then re-armed 2 after wrap
    do_reset(); tx_req_rdy = 1'b1;
    cmd0(2, 2'd0, 2'd1, 2'd0); cyc(1);
    cmd0(7, 2'd0, 2'd1, 2'd0); cyc(1);
    cmd0(15, 2'd0, 2'd1, 2'd0); cyc(1); idle();
    n = 0;
    while (!(tx_req_val && tx_req_flowid == FW'(7)) && n < 40) begin cyc(1); n++; end
    chk("wait_grant7_timeout", 32'(tx_req_val && tx_req_flowid == FW'(7)), 32'd1);
    cmd0(2, 2'd0, 2'd1, 2'd0); cyc(1); idle(); cyc(60);
    q = '{2*8+2, 7*8+2, 15*8+2, 2*8+2}; chk_log("round_robin", q);

    // stall 10 cycles; SET during stall yields a second grant
    do_reset(); tx_req_rdy = 1'b0;
    cmd0(6, 2'd0, 2'd1, 2'd0); cyc(1); idle();
    wait_val(40);
    f0 = tx_req_flowid; k0 = tx_req_kinds;
    chk("stall_flowid", 32'(f0), 32'd6);
    chk("stall_kinds", 32'(k0), 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk("stall_val_hold", 32'(tx_req_val), 32'd1);
      chk("stall_fid_hold", 32'(tx_req_flowid), 32'(f0));
      chk("stall_kinds_hold", 32'(tx_req_kinds), 32'(k0));
      if (i == 3) cmd0(6, 2'd0, 2'd1, 2'd0); else idle();
      cyc(1);
    end
    idle(); tx_req_rdy = 1'b1; cyc(40);
    q = '{6*8+2, 6*8+2}; chk_log("stall_rearm", q);

    // grab of flow 4 at cycle 4 collides with SET ack -> ack survives
    do_reset(); tx_req_rdy = 1'b1;
    cmd0(4, 2'd0, 2'd1, 2'd0); cyc(1); idle(); cyc(3);
    cmd0(4, 2'd1, 2'd0, 2'd0); cyc(1); idle(); cyc(40);
    q = '{4*8+2, 4*8+1}; chk_log("grab_vs_set", q);

    // same collision with CLEAR of the grabbed kind -> nothing left
    do_reset(); tx_req_rdy = 1'b1;
    cmd0(4, 2'd0, 2'd1, 2'd0); cyc(1); idle(); cyc(3);
    cmd0(4, 2'd0, 2'd2, 2'd0); cyc(1); idle(); cyc(40);
    q = '{4*8+2}; chk_log("grab_vs_clear", q);

    // reset during ISSUE drops the grant and all pending state
    do_reset(); tx_req_rdy = 1'b0;
    cmd0(1, 2'd1, 2'd1, 2'd1); cyc(1); idle();
    wait_val(40);
    cmd0(9, 2'd1, 2'd0, 2'd0);
    rst = 1'b1; cyc(1); rst = 1'b0; idle();
    chk("rst_drop_val", 32'(tx_req_val), 32'd0);
    glog.delete(); tx_req_rdy = 1'b1; cyc(40);
    chk("rst_no_grants", 32'(glog.size()), 32'd0);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      idle();
      if ($urandom_range(0, 9) < 3)
        cmd0($urandom_range(0, NF-1), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) < 3)
        cmd1($urandom_range(0, NF-1), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      tx_req_rdy = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; idle(); cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
